// File: rtl/memory_access_m_stage_if.sv
// Data-memory req/ack bus between the M stage (master) and the memory (slave).
// Request fields are held stable by the master until ack; rdata is valid with ack.
interface memory_access_m_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/memory_access_m_stage.sv
// M-stage load/store unit. Latency: IDLE->BUSY (until ack or timeout)->DONE, min 3 cycles.
// Backpressure: m_stall_o holds the pipeline from access start until DONE; DONE lasts one cycle.
module memory_access_m_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [6:0]  LOAD_OPCODE    = 7'b0000011,
  parameter logic [6:0]  STORE_OPCODE   = 7'b0100011
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        M_valid_i,
  input  logic [6:0]  M_opcode_i,
  input  logic [2:0]  M_funct3_i,
  input  logic [31:0] M_valE_i,
  input  logic [31:0] M_valB_i,
  memory_access_m_stage_if.master dmem,
  output logic [31:0] m_valM_o,
  output logic        m_stall_o,
  output logic        m_misalign_o,
  output logic        m_bus_err_o
);
  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req, r_we, r_is_load, r_err;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [7:0]  r_cnt;

  logic        w_is_load, w_is_store, w_mem, w_legal, w_aligned, w_access;
  logic        w_ack, w_timeout;
  logic [7:0]  w_cnt_nxt;
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_data, w_ld_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_is_load  = (M_opcode_i == LOAD_OPCODE);
  assign w_is_store = (M_opcode_i == STORE_OPCODE);
  assign w_mem      = M_valid_i & (w_is_load | w_is_store);

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    if (w_is_load)
      w_legal = (M_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (w_is_store)
      w_legal = (M_funct3_i inside {3'b000, 3'b001, 3'b010});
    case (M_funct3_i[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~M_valE_i[0];
      2'b10:   w_aligned = (M_valE_i[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_access = w_mem & w_legal & w_aligned;

  // Store lanes: replicate the datum so any byte/half lane picks it up under its strobe.
  always_comb begin
    w_st_strb = 4'b0000;
    w_st_data = 32'h0;
    if (w_is_store) begin
      case (M_funct3_i[1:0])
        2'b00: begin
          w_st_strb = 4'b0001 << M_valE_i[1:0];
          w_st_data = {4{M_valB_i[7:0]}};
        end
        2'b01: begin
          w_st_strb = 4'b0011 << M_valE_i[1:0];
          w_st_data = {2{M_valB_i[15:0]}};
        end
        default: begin
          w_st_strb = 4'b1111;
          w_st_data = M_valB_i;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = dmem.dmem_rdata_i[7:0];
    case (r_addr_lo)
      2'd1:    w_byte = dmem.dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem.dmem_rdata_i[23:16];
      2'd3:    w_byte = dmem.dmem_rdata_i[31:24];
      default: w_byte = dmem.dmem_rdata_i[7:0];
    endcase
    w_half = r_addr_lo[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_ext = {24'h0, w_byte};
      3'b101:  w_ld_ext = {16'h0, w_half};
      default: w_ld_ext = dmem.dmem_rdata_i;
    endcase
  end

  assign w_ack     = dmem.dmem_ack_i & r_req;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_timeout = ~w_ack & (w_cnt_nxt == TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_wstrb   <= 4'b0000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_data    <= 32'h0;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_is_load <= 1'b0;
      r_cnt     <= 8'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_access) begin
          r_req     <= 1'b1;
          r_we      <= w_is_store;
          r_wstrb   <= w_st_strb;
          r_addr    <= {M_valE_i[31:2], 2'b00};
          r_wdata   <= w_st_data;
          r_funct3  <= M_funct3_i;
          r_addr_lo <= M_valE_i[1:0];
          r_is_load <= w_is_load;
          r_data    <= 32'h0;
          r_cnt     <= 8'h0;
          r_err     <= 1'b0;
        end
        S_BUSY: begin
          if (w_ack || w_timeout) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_data  <= w_ack ? w_ld_ext : 32'h0;
            r_err   <= ~w_ack;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_err <= 1'b0;
      endcase
    end
  end

  assign dmem.dmem_req_o   = r_req;
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_wdata_o = r_wdata;
  assign dmem.dmem_wstrb_o = r_wstrb;

  // Reset gates the status outputs immediately even though the state clears on the next edge.
  assign m_stall_o    = ~rst_i & (((r_state == S_IDLE) & w_access) | (r_state == S_BUSY));
  assign m_misalign_o = ~rst_i & (r_state == S_IDLE) & w_mem & ~(w_legal & w_aligned);
  assign m_valM_o     = (~rst_i & (r_state == S_DONE) & r_is_load) ? r_data : 32'h0;
  assign m_bus_err_o  = ~rst_i & (r_state == S_DONE) & r_err;
endmodule

// File: doc/memory_access_m_stage.md
Name: memory_access_m_stage

Overview:
- M-stage data-memory access unit of the 5-stage RISC-V pipeline.
- Takes the instruction held in the E→M register and performs the load or store over a req/ack data bus. Loads are byte/half/word with sign or zero extension.
- Produces m_valM_o, which feeds the W pipeline register.
- Asserts m_stall_o to the hazard unit while an access is outstanding. The hazard unit then stalls F..M and bubbles W.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles without ack before a bus error is forced (1..255).
- LOAD_OPCODE, 7'b0000011: opcode of load instructions.
- STORE_OPCODE, 7'b0100011: opcode of store instructions.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- M_valid_i  in  1  M register holds a real (non-bubble) instruction
- M_opcode_i  in  7  instruction opcode
- M_funct3_i  in  3  access size/sign
- M_valE_i  in  32  effective address from ALU
- M_valB_i  in  32  store data (rs2)
- dmem_req_o  out  1  bus request; held until ack
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  32  store data, lane-shifted
- dmem_wstrb_o  out  4  byte enables
- dmem_rdata_i  in  32  read word, valid with ack
- dmem_ack_i  in  1  access complete
- m_valM_o  out  32  extended load result
- m_stall_o  out  1  pipeline must hold M and upstream
- m_misalign_o  out  1  misaligned/illegal access, no bus cycle issued
- m_bus_err_o  out  1  access ended by timeout (one-cycle pulse, in DONE)

Behaviour:
- Access condition:
  - access = M_valid_i & (opcode==LOAD_OPCODE | opcode==STORE_OPCODE) & legal & aligned.
  - Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Aligned: half needs addr[0]==0; word needs addr[1:0]==0.
- m_misalign_o:
  - Combinational: M_valid_i & (load|store) & (illegal funct3 | misaligned), asserted in IDLE only.
  - When asserted: no request is issued, no stall, m_valM_o = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if access, latch addr, we, wstrb, wdata, funct3 and go to BUSY; otherwise stay.
  - BUSY: dmem_req_o = 1. Each cycle:
    - dmem_ack_i = 1: capture the extended load data and go to DONE.
    - Counter reaches TIMEOUT_CYCLES without ack: drop req, load data = 0, set bus-error flag, go to DONE.
  - DONE: one cycle only, then IDLE. m_valM_o is valid and the pipeline advances this cycle.
- m_stall_o = (IDLE & access) | BUSY. It is 0 in DONE, so the completed instruction moves to W exactly once.
- Ack is ignored unless dmem_req_o = 1.
- Bus request fields:
  - dmem_req_o and the other bus outputs are registered and stable for the whole of BUSY.
  - dmem_we_o = 0 and dmem_wstrb_o = 0 for loads.
- Store strobes and data:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = valB.
- Load extraction:
  - Byte lane is selected by addr[1:0]; half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- m_valM_o:
  - In DONE of a load: the captured value.
  - In all other cycles, and for stores: 0.
- m_bus_err_o: 1 only in the DONE cycle of a timed-out access.
- Timeout counter: 8-bit. Cleared on entry to BUSY, increments each BUSY cycle without ack.
- Minimum load latency: ack in the first BUSY cycle gives stall for 2 cycles (IDLE, BUSY), and result in cycle 3 (DONE).
- Reset:
  - Applies in any state, including BUSY mid-access.
  - State → IDLE. dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o, the captured data, the counter and the error flag are all cleared to 0.
  - Outputs m_valM_o, m_stall_o, m_misalign_o and m_bus_err_o are 0 while reset is held. A late ack after reset is ignored.
- A bubble (M_valid_i = 0) never starts an access. The hazard unit does not flush M while m_stall_o = 1.

Test Plan:
- Load LW, addr 0x100, ack on first BUSY cycle, rdata 0xDEADBEEF → req=1 for 1 cycle with addr 0x100, we=0; stall high 2 cycles; DONE: m_valM_o = 0xDEADBEEF, stall 0.
- Load LB addr 0x203, rdata 0x80112233, then LBU same → m_valM_o = 0xFFFFFF80 for LB, then 0x00000080 for LBU; LH addr 0x202 → 0xFFFF8011.
- Store SB addr 0x41, valB 0x000000A5 → wstrb = 0010, wdata = 0xA5A5A5A5, addr = 0x40, we=1; SH addr 0x42, valB 0x1234 → wstrb = 1100; m_valM_o stays 0.
- LW addr 0x102 and SH addr 0x101 → m_misalign_o = 1, dmem_req_o never rises, m_stall_o = 0; funct3 = 011 load also gives misalign.
- TIMEOUT_CYCLES = 4, ack never asserted → req high 4 cycles then low; DONE with m_bus_err_o = 1 pulse, m_valM_o = 0, stall drops.
- rst_i asserted in the 2nd BUSY cycle, then ack pulsed the next cycle → next cycle IDLE, req = 0, stall = 0, ack has no effect; a subsequent LW completes normally.
